// File: rtl/uart_tx_fifo_core.sv
// uart_tx_fifo_core: UART transmitter with a free-running baud tick generator and a TX FIFO.
// The host pushes words into the FIFO. The FSM pops each word and sends it LSB first as
// start, DBITS data bits, an optional parity bit and a stop period.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit whose sense is PARITY_ODD.
module uart_tx_fifo_core #(
  parameter int DBITS      = 8,
  parameter int SB_TICK    = 16,
  parameter int BR_LIMIT   = 204,
  parameter int BR_BITS    = 8,
  parameter int FIFO_AW    = 2,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [DBITS-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic [FIFO_AW:0] count,
  output logic             overflow,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  localparam int                 Depth  = 1 << FIFO_AW;
  localparam int                 NW     = (DBITS > 1) ? $clog2(DBITS) : 1;
  localparam logic [BR_BITS-1:0] BrLast = BR_BITS'(BR_LIMIT - 1);
  localparam logic [FIFO_AW:0]   DepthW = (FIFO_AW + 1)'(Depth);
  localparam logic [NW-1:0]      NLast  = NW'(DBITS - 1);
  // SB_TICK = 32 maps to 31, so a 5-bit tick counter covers two stop bits.
  localparam logic [4:0]         SLast  = 5'(SB_TICK - 1);
  localparam logic [4:0]         BitEnd = 5'd15;

  // Reject parameter sets the counters cannot represent.
  if (PARITY_ODD > 1 || (2 ** BR_BITS) < BR_LIMIT) begin : g_param_check
    $error("uart_tx_fifo_core: invalid parameter combination");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  // ---------------------------------------------------------------------------
  // Baud tick generator
  // ---------------------------------------------------------------------------
  logic [BR_BITS-1:0] br_q, br_d;
  logic               tick;

  // Free-running counter; tick marks the last cycle of each period.
  always_comb begin
    tick = (br_q == BrLast);
    br_d = tick ? '0 : br_q + 1'b1;
  end

  // Baud counter register.
  always_ff @(posedge clk_100MHz) begin
    if (reset) br_q <= '0;
    else       br_q <= br_d;
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [DBITS-1:0]   mem_q [Depth];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               full_q, full_d, empty_q, empty_d, overflow_q, overflow_d;
  logic               pop, push;

  // A write while full is accepted only if the FSM frees a slot in the same cycle.
  always_comb begin
    push       = wr_en && (!full_q || pop);
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    full_d     = (count_d == DepthW);
    empty_d    = (count_d == '0);
    overflow_d = overflow_q | (wr_en & full_q & ~pop);
  end

  // FIFO pointers, occupancy and registered flags.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_100MHz) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [4:0]       s_q, s_d;
  logic [NW-1:0]    n_q, n_d;
  logic [DBITS-1:0] shreg_q, shreg_d;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  // FSM and datapath registers.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      shreg_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shreg_q <= shreg_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic; all bit phases advance only on baud ticks.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!empty_q) begin
          pop     = 1'b1;
          shreg_d = mem_q[rptr_q];
          s_d     = '0;
          n_d     = '0;
`ifdef UART_TX_PARITY_EN
          par_d   = (^mem_q[rptr_q]) ^ 1'(PARITY_ODD);
`endif
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          if (s_q == BitEnd) begin
            s_d     = '0;
            state_d = StData;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (s_q == BitEnd) begin
            s_d     = '0;
            shreg_d = shreg_q >> 1;
            if (n_q == NLast) begin
              n_d = '0;
`ifdef UART_TX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (tick) begin
          if (s_q == BitEnd) begin
            s_d     = '0;
            state_d = StStop;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      StStop: begin
        if (tick) begin
          if (s_q == SLast) begin
            s_d     = '0;
            state_d = StIdle;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    tx      = 1'b1;
    busy    = (state_q != StIdle);
    tx_done = (state_q == StStop) && tick && (s_q == SLast);
    unique case (state_q)
      StIdle:   tx = 1'b1;
      StStart:  tx = 1'b0;
      StData:   tx = shreg_q[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx = par_q;
`endif
      StStop:   tx = 1'b1;
      default:  tx = 1'b1;
    endcase
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo_core.sv
// Bench for uart_tx_fifo_core with a fast baud rate (BR_LIMIT=4, one bit = 64 clk).
// A frame-level reference model predicts FIFO state and line level every cycle; a serial
// monitor decodes frames from tx and checks them against a queue of expected words.
module tb_uart_tx_fifo_core;

  localparam int DBITS      = 8;
  localparam int SB_TICK    = 16;
  localparam int BR_LIMIT   = 4;
  localparam int BR_BITS    = 8;
  localparam int FIFO_AW    = 2;
  localparam int PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FT    = (1 + DBITS + P) * 16 + SB_TICK;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int NBITS = DBITS + 2 + P;

  logic             clk, reset, wr_en;
  logic [DBITS-1:0] wr_data;
  logic             full, empty, overflow, tx, busy, tx_done;
  logic [FIFO_AW:0] count;

  uart_tx_fifo_core #(
    .DBITS     (DBITS),
    .SB_TICK   (SB_TICK),
    .BR_LIMIT  (BR_LIMIT),
    .BR_BITS   (BR_BITS),
    .FIFO_AW   (FIFO_AW),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk_100MHz(clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state describing the current clock cycle.
  bit               m_valid = 0;
  int               m_phase;      // position within the baud period
  bit               m_idle;
  int               m_left;       // ticks remaining in the current frame
  logic [DBITS-1:0] m_word;
  bit               m_ovf;
  logic [DBITS-1:0] m_fifo[$];
  logic [DBITS-1:0] exp_q[$];
  int               rst_gen = 0;

  task automatic model_step();
    bit               tk, was_full, popped;
    logic [DBITS-1:0] w;
    if (reset) begin
      if (m_valid && !m_idle && exp_q.size() > 0) void'(exp_q.pop_back());
      m_valid = 1;
      m_phase = 0;
      m_idle  = 1;
      m_left  = 0;
      m_ovf   = 0;
      m_fifo.delete();
      rst_gen++;
      return;
    end
    if (!m_valid) return;
    tk       = (m_phase == BR_LIMIT - 1);
    was_full = (m_fifo.size() == DEPTH);
    popped   = m_idle && (m_fifo.size() > 0);
    if (popped) begin
      w = m_fifo.pop_front();
      exp_q.push_back(w);
      m_word = w;
      m_idle = 0;
      m_left = FT;
    end else if (!m_idle && tk) begin
      m_left--;
      if (m_left == 0) m_idle = 1;
    end
    if (wr_en) begin
      if (!was_full || popped) m_fifo.push_back(wr_data);
      else m_ovf = 1;
    end
    m_phase = (m_phase + 1) % BR_LIMIT;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  function automatic int exp_tx();
    int idx;
    if (m_idle) return 1;
    idx = (FT - m_left) / 16;
    if (idx == 0) return 0;
    if (idx <= DBITS) return int'(m_word[idx-1]);
    if (P == 1 && idx == DBITS + 1) return int'(^m_word) ^ (PARITY_ODD != 0 ? 1 : 0);
    return 1;
  endfunction

  // Cycle checker: compares every output against the model.
  int done_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("tx", int'(tx), exp_tx());
      chk("busy", int'(busy), int'(!m_idle));
      chk("tx_done", int'(tx_done),
          int'(!m_idle && m_phase == BR_LIMIT - 1 && m_left == 1));
      chk("count", int'(count), m_fifo.size());
      chk("full", int'(full), int'(m_fifo.size() == DEPTH));
      chk("empty", int'(empty), int'(m_fifo.size() == 0));
      chk("overflow", int'(overflow), int'(m_ovf));
      if (tx_done === 1'b1) done_cnt++;
    end
  end

  // Serial monitor: decodes each frame at mid-bit and scores it against exp_q.
  bit mon_en = 0;
  int frames = 0;
  initial begin
    int          g;
    logic [15:0] fr, efr;
    logic [DBITS-1:0] w;
    wait (mon_en);
    forever begin
      @(negedge tx);
      g  = rst_gen;
      fr = '0;
      for (int j = 0; j < NBITS; j++) begin
        repeat ((j == 0) ? 32 : 64) @(negedge clk);
        fr[j] = tx;
      end
      if (g == rst_gen) begin
        if (exp_q.size() == 0) begin
          chk("frame_expected", 0, 1);
        end else begin
          w   = exp_q.pop_front();
          efr = '0;
          efr[0] = 1'b0;
          for (int k = 0; k < DBITS; k++) efr[k+1] = w[k];
          if (P == 1) efr[DBITS+1] = (^w) ^ (PARITY_ODD != 0);
          efr[NBITS-1] = 1'b1;
          chk("frame", int'(fr), int'(efr));
          frames++;
        end
      end
    end
  end

  task automatic push(input logic [DBITS-1:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 8000; i++) begin
      @(posedge clk);
      #1;
      if (m_idle && m_fifo.size() == 0) break;
    end
    if (i == 8000) chk("drain_timeout", 0, 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) break;
    end
    if (i == 2000) chk("tx_done_timeout", 0, 1);
  endtask

  initial begin
    int d0, f0;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1;
    @(negedge clk);
    chk("reset_tx", int'(tx), 1);
    chk("reset_empty", int'(empty), 1);
    repeat (5) @(posedge clk);
    #1;

    // Single word from idle: start bit appears two cycles after the write.
    d0 = done_cnt;
    f0 = frames;
    wr_en   = 1'b1;
    wr_data = 8'h55;
    @(negedge clk);
    chk("t1_c0_tx", int'(tx), 1);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    chk("t1_c1_tx", int'(tx), 1);
    @(negedge clk);
    chk("t1_c2_tx", int'(tx), 0);
    drain();
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_frames", frames - f0, 1);

    // Four words back to back.
    d0 = done_cnt;
    f0 = frames;
    push(8'hA5);
    push(8'h3C);
    push(8'h00);
    push(8'hFF);
    drain();
    chk("t2_done", done_cnt - d0, 4);
    chk("t2_frames", frames - f0, 4);

    // Six-word burst: one popped, four buffered, one dropped.
    f0 = frames;
    for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
    @(negedge clk);
    chk("t3_overflow", int'(overflow), 1);
    chk("t3_full", int'(full), 1);
    drain();
    chk("t3_frames", frames - f0, 5);
    pulse_reset();
    @(negedge clk);
    chk("t3_ovf_cleared", int'(overflow), 0);

    // Reset in the middle of a frame.
    push(8'hC3);
    repeat (300) @(posedge clk);
    #1;
    d0 = done_cnt;
    pulse_reset();
    @(negedge clk);
    chk("t4_tx_idle", int'(tx), 1);
    chk("t4_empty", int'(empty), 1);
    repeat (700) @(posedge clk);
    #1;
    chk("t4_no_done", done_cnt - d0, 0);
    f0 = frames;
    push(8'h96);
    drain();
    chk("t4_frames", frames - f0, 1);

    // Parity-sensitive pattern (three ones).
    f0 = frames;
    push(8'h07);
    drain();
    chk("t5_frames", frames - f0, 1);

    // Full FIFO with a simultaneous pop and write.
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    push(8'h05);
    @(negedge clk);
    chk("t6_full_before", int'(full), 1);
    wait_done();
    @(posedge clk);
    #1;
    wr_en   = 1'b1;
    wr_data = 8'h06;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    chk("t6_count", int'(count), 4);
    chk("t6_overflow", int'(overflow), 0);
    drain();

    // Randomised bursts and gaps.
    for (int it = 0; it < 15; it++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        wr_en   = ($urandom_range(0, 3) != 0);
        wr_data = 8'($urandom);
        @(posedge clk);
        #1;
      end
      wr_en = 1'b0;
      repeat ($urandom_range(0, 1200)) @(posedge clk);
      #1;
    end
    drain();
    repeat (20) @(posedge clk);
    chk("leftover_frames", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
